formula_n_fsm: RTL and testbench

- Computes the nested formula res = isqrt(x[0] + isqrt(x[1] + ... + isqrt(x[N-1]))) for N operands.
- Shares one external isqrt unit across all steps.
- Parametrised successor of the fixed three-operand formula FSM. Adds:
  - generic operand count and width;
  - an input-ready handshake;
  - operand capture, so inputs need not stay stable while the computation runs.
- Sits between an argument source and a single pipelined isqrt instance, in the same slot as the three-operand FSM inside the sqrt formula distributor.

---
 rtl/formula_n_fsm_pkg.sv | 31 +++
 rtl/formula_n_fsm.sv | 119 +++++++++++
 tb/tb_formula_n_fsm.sv | 378 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/formula_n_fsm_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : formula_n_pkg
//  Purpose  : Shared types and elaboration helpers for formula_n_fsm.
//             - state_t      : FSM state encoding (idle / waiting on isqrt)
//             - step_width() : width of the down-counting step register
//             - params_legal(): legality of the N / W parameter pair
//  Revision : 1.0  initial release
// ============================================================================
package formula_n_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    localparam int c_N_MIN = 1;
    localparam int c_N_MAX = 16;

    // The step counter must hold N-1; a single operand still needs one bit.
    function automatic int step_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // W must be even so that the isqrt result is exactly W/2 bits wide.
    function automatic bit params_legal(input int n, input int w);
        return (n >= c_N_MIN) && (n <= c_N_MAX) && (w >= 2) && ((w % 2) == 0);
    endfunction

endpackage : formula_n_pkg
`default_nettype wire

// File: rtl/formula_n_fsm.sv
`default_nettype none
// ============================================================================
//  Module   : formula_n_fsm
//  Purpose  : Computes res = isqrt(x[0] + isqrt(x[1] + ... + isqrt(x[N-1])))
//             by time-sharing one external pipelined isqrt unit.
//  Ports    : clk, rst_n                 clock, async active-low reset
//             arg_vld / arg_rdy / args    operand vector handshake, x[i] =
//                                         args[i*W +: W]
//             res_vld / res               one-cycle result pulse, result
//                                         zero-extended from W/2 bits
//             isqrt_x_vld / isqrt_x       request to the isqrt unit
//             isqrt_y_vld / isqrt_y       response from the isqrt unit
//  Revision : 1.0  initial release
// ============================================================================
module formula_n_fsm
    import formula_n_pkg::*;
#(
    parameter  int N  = 3,
    parameter  int W  = 32,
    localparam int YW = W / 2
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           arg_vld,
    output logic           arg_rdy,
    input  logic [N*W-1:0] args,
    output logic           res_vld,
    output logic [W-1:0]   res,
    output logic           isqrt_x_vld,
    output logic [W-1:0]   isqrt_x,
    input  logic           isqrt_y_vld,
    input  logic [YW-1:0]  isqrt_y
);

    localparam int c_SW    = step_width(N);
    // Operand store sized to a power of two so the step-derived index is
    // exactly c_SW bits wide; entries at and above N-1 are never written.
    localparam int c_DEPTH = 1 << c_SW;

    generate
        if (!params_legal(N, W)) begin : g_param_check
            $error("formula_n_fsm: illegal parameters N=%0d W=%0d", N, W);
        end
    endgenerate

    state_t          r_state;
    logic [c_SW-1:0] r_step;
    logic [W-1:0]    r_xreg [c_DEPTH];
    logic            r_res_vld;
    logic [W-1:0]    r_res;

    logic [c_SW-1:0] w_idx;
    logic            w_last;
    logic [W-1:0]    w_top;
    logic [W-1:0]    w_y_ext;
    logic [W-1:0]    w_sum;

    assign w_idx   = r_step - c_SW'(1);
    assign w_last  = (r_step == '0);
    // The innermost operand goes straight to the isqrt unit in the accept
    // cycle, so it is never stored.
    assign w_top   = args[(N-1)*W +: W];
    assign w_y_ext = {{(W-YW){1'b0}}, isqrt_y};
    // Modulo-2^W sum: the carry out is intentionally dropped.
    assign w_sum   = r_xreg[w_idx] + w_y_ext;

    assign arg_rdy = (r_state == ST_IDLE);

    // Reissue happens in the same cycle as the response, which keeps exactly
    // one request in flight and avoids a bubble per step.
    assign isqrt_x_vld = arg_rdy ? arg_vld : (isqrt_y_vld && !w_last);
    assign isqrt_x     = arg_rdy ? w_top   : w_sum;

    assign res_vld = r_res_vld;
    assign res     = r_res;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_step    <= '0;
            r_res_vld <= 1'b0;
            r_res     <= '0;
            for (int i = 0; i < c_DEPTH; i++) begin
                r_xreg[i] <= '0;
            end
        end else begin
            r_res_vld <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    // Responses arriving while idle belong to an abandoned
                    // computation and are dropped.
                    if (arg_vld) begin
                        for (int i = 0; i < N - 1; i++) begin
                            r_xreg[i] <= args[i*W +: W];
                        end
                        r_step  <= c_SW'(N - 1);
                        r_state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (isqrt_y_vld) begin
                        if (w_last) begin
                            r_state   <= ST_IDLE;
                            r_res_vld <= 1'b1;
                            r_res     <= w_y_ext;
                        end else begin
                            r_step <= w_idx;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule : formula_n_fsm
`default_nettype wire

// File: tb/tb_formula_n_fsm.sv
`default_nettype none
// ============================================================================
//  Module   : tb_formula_n_fsm
//  Purpose  : Self-checking bench for formula_n_fsm. Three instances (N=3,
//             N=2, N=1, W=32) share clock and reset; a behavioural isqrt
//             unit with per-transaction latency answers their requests.
//  Revision : 1.0  initial release
// ============================================================================
module tb_formula_n_fsm;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    logic        arg_vld     [3];
    logic [95:0] args        [3];
    logic        isqrt_y_vld [3];
    logic [15:0] isqrt_y     [3];
    logic        arg_rdy     [3];
    logic        res_vld     [3];
    logic [31:0] res         [3];
    logic        isqrt_x_vld [3];
    logic [31:0] isqrt_x     [3];

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Behavioural isqrt unit state (one outstanding request at most).
    bit          pend_vld = 1'b0;
    int          pend_due = 0;
    logic [15:0] pend_y   = '0;
    int          acc_cyc  = 0;
    logic [31:0] obs_req [16];

    always #5 clk = ~clk;

    formula_n_fsm #(.N(3), .W(32)) u_dut3 (
        .clk(clk), .rst_n(rst_n),
        .arg_vld(arg_vld[0]), .arg_rdy(arg_rdy[0]), .args(args[0]),
        .res_vld(res_vld[0]), .res(res[0]),
        .isqrt_x_vld(isqrt_x_vld[0]), .isqrt_x(isqrt_x[0]),
        .isqrt_y_vld(isqrt_y_vld[0]), .isqrt_y(isqrt_y[0])
    );

    formula_n_fsm #(.N(2), .W(32)) u_dut2 (
        .clk(clk), .rst_n(rst_n),
        .arg_vld(arg_vld[1]), .arg_rdy(arg_rdy[1]), .args(args[1][63:0]),
        .res_vld(res_vld[1]), .res(res[1]),
        .isqrt_x_vld(isqrt_x_vld[1]), .isqrt_x(isqrt_x[1]),
        .isqrt_y_vld(isqrt_y_vld[1]), .isqrt_y(isqrt_y[1])
    );

    formula_n_fsm #(.N(1), .W(32)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .arg_vld(arg_vld[2]), .arg_rdy(arg_rdy[2]), .args(args[2][31:0]),
        .res_vld(res_vld[2]), .res(res[2]),
        .isqrt_x_vld(isqrt_x_vld[2]), .isqrt_x(isqrt_x[2]),
        .isqrt_y_vld(isqrt_y_vld[2]), .isqrt_y(isqrt_y[2])
    );

    // floor(sqrt(x)) by bitwise trial, in 64-bit arithmetic.
    function automatic logic [15:0] ref_isqrt(input logic [31:0] x);
        longint y = 0;
        longint t;
        for (int b = 15; b >= 0; b--) begin
            t = y | (longint'(1) << b);
            if (t * t <= longint'(x)) y = t;
        end
        return y[15:0];
    endfunction

    // Nested formula evaluated from the innermost operand outward.
    function automatic logic [31:0] ref_formula(input logic [95:0] v, input int n);
        logic [31:0] acc;
        logic [31:0] s;
        acc = {16'h0, ref_isqrt(v[(n-1)*32 +: 32])};
        for (int i = n - 2; i >= 0; i--) begin
            s   = v[i*32 +: 32] + acc;
            acc = {16'h0, ref_isqrt(s)};
        end
        return acc;
    endfunction

    function automatic logic [31:0] rand_word();
        if ($urandom_range(0, 2) == 0) return $urandom();
        return $urandom_range(0, 1000);
    endfunction

    function automatic logic [95:0] rand_vec();
        return {rand_word(), rand_word(), rand_word()};
    endfunction

    // Runs one operand vector on instance d. Protocol behaviour (request
    // values and timing, arg_rdy, res_vld pulse) is checked cycle by cycle
    // against the expected request chain; callers check the scenario values.
    task automatic drive_vector(input int d, input int n, input int lat,
                                input logic [95:0] vec, input bit pre_acc,
                                input bit bp, input int abort_after,
                                input bit has_next, input logic [95:0] nxt,
                                input string nm, output logic [31:0] o_res);
        logic [31:0] ereq [16];
        logic [31:0] eres;
        int          nreq;
        int          ny;
        bit          y_now;
        bit          done;
        o_res   = '0;
        ereq[0] = vec[(n-1)*32 +: 32];
        for (int k = 1; k < n; k++)
            ereq[k] = vec[(n-1-k)*32 +: 32] + {16'h0, ref_isqrt(ereq[k-1])};
        eres = {16'h0, ref_isqrt(ereq[n-1])};

        if (!pre_acc) begin
            @(posedge clk); #1; cyc++;
            arg_vld[d] = 1'b1; args[d] = vec; isqrt_y_vld[d] = 1'b0;
            @(negedge clk);
            checks++;
            if (arg_rdy[d] !== 1'b1 || isqrt_x_vld[d] !== 1'b1 || isqrt_x[d] !== ereq[0]) begin
                errors++;
                $display("FAIL %s accept: rdy=%b xvld=%b x=%h, want rdy=1 xvld=1 x=%h",
                         nm, arg_rdy[d], isqrt_x_vld[d], isqrt_x[d], ereq[0]);
            end
            obs_req[0] = isqrt_x[d];
            pend_vld = 1'b1; pend_due = cyc + lat; pend_y = ref_isqrt(isqrt_x[d]);
            acc_cyc = cyc;
        end
        nreq = 1; ny = 0; done = 1'b0;

        for (int i = 0; i < n * lat + 4 && !done; i++) begin
            if (abort_after != 0 && ny == abort_after) begin
                @(posedge clk); #1; cyc++;
                isqrt_y_vld[d] = 1'b0; arg_vld[d] = 1'b0; rst_n = 1'b0;
                #1;
                checks++;
                if (res_vld[d] !== 1'b0 || res[d] !== 32'h0 || arg_rdy[d] !== 1'b1 || isqrt_x_vld[d] !== 1'b0) begin
                    errors++;
                    $display("FAIL %s async_reset: res_vld=%b res=%h rdy=%b xvld=%b, want 0 0 1 0",
                             nm, res_vld[d], res[d], arg_rdy[d], isqrt_x_vld[d]);
                end
                @(posedge clk); #1; cyc++;
                rst_n = 1'b1;
                for (int j = 0; j < lat + 3; j++) begin
                    @(posedge clk); #1; cyc++;
                    y_now = pend_vld && (pend_due == cyc);
                    isqrt_y_vld[d] = y_now; isqrt_y[d] = pend_y;
                    if (y_now) pend_vld = 1'b0;
                    @(negedge clk);
                    checks++;
                    if (res_vld[d] !== 1'b0 || isqrt_x_vld[d] !== 1'b0 || arg_rdy[d] !== 1'b1) begin
                        errors++;
                        $display("FAIL %s late_y_ignored: res_vld=%b xvld=%b rdy=%b, want 0 0 1",
                                 nm, res_vld[d], isqrt_x_vld[d], arg_rdy[d]);
                    end
                end
                isqrt_y_vld[d] = 1'b0;
                return;
            end

            @(posedge clk); #1; cyc++;
            arg_vld[d] = bp;
            args[d]    = {$urandom(), $urandom(), $urandom()};
            y_now      = pend_vld && (pend_due == cyc);
            isqrt_y_vld[d] = y_now;
            isqrt_y[d]     = y_now ? pend_y : 16'($urandom());
            if (y_now) begin
                pend_vld = 1'b0;
                ny++;
            end
            @(negedge clk);
            checks++;
            if (y_now && nreq < n) begin
                if (isqrt_x_vld[d] !== 1'b1 || isqrt_x[d] !== ereq[nreq]) begin
                    errors++;
                    $display("FAIL %s request%0d: xvld=%b x=%h, want xvld=1 x=%h",
                             nm, nreq, isqrt_x_vld[d], isqrt_x[d], ereq[nreq]);
                end
                if (isqrt_x_vld[d] === 1'b1) begin
                    obs_req[nreq] = isqrt_x[d];
                    pend_vld = 1'b1; pend_due = cyc + lat; pend_y = ref_isqrt(isqrt_x[d]);
                end
                nreq++;
            end else if (isqrt_x_vld[d] !== 1'b0) begin
                errors++;
                $display("FAIL %s no_request: xvld=%b, want 0", nm, isqrt_x_vld[d]);
            end
            checks++;
            if (arg_rdy[d] !== 1'b0 || res_vld[d] !== 1'b0) begin
                errors++;
                $display("FAIL %s wait_state: rdy=%b res_vld=%b, want 0 0", nm, arg_rdy[d], res_vld[d]);
            end
            if (y_now && ny == n) done = 1'b1;
        end

        if (!done) begin
            checks++; errors++;
            $display("FAIL %s timeout: responses=%0d, want %0d", nm, ny, n);
            isqrt_y_vld[d] = 1'b0; arg_vld[d] = 1'b0;
            return;
        end

        @(posedge clk); #1; cyc++;
        isqrt_y_vld[d] = 1'b0;
        arg_vld[d]     = has_next;
        args[d]        = has_next ? nxt : {$urandom(), $urandom(), $urandom()};
        @(negedge clk);
        checks++;
        if (res_vld[d] !== 1'b1 || res[d] !== eres) begin
            errors++;
            $display("FAIL %s result: res_vld=%b res=%h, want 1 %h", nm, res_vld[d], res[d], eres);
        end
        checks++;
        if (arg_rdy[d] !== 1'b1) begin
            errors++;
            $display("FAIL %s rdy_in_res_cycle: rdy=%b, want 1", nm, arg_rdy[d]);
        end
        o_res = res[d];
        if (has_next) begin
            checks++;
            if (isqrt_x_vld[d] !== 1'b1 || isqrt_x[d] !== nxt[(n-1)*32 +: 32]) begin
                errors++;
                $display("FAIL %s next_accept: xvld=%b x=%h, want 1 %h",
                         nm, isqrt_x_vld[d], isqrt_x[d], nxt[(n-1)*32 +: 32]);
            end
            obs_req[0] = isqrt_x[d];
            pend_vld = 1'b1; pend_due = cyc + lat; pend_y = ref_isqrt(isqrt_x[d]);
            acc_cyc = cyc;
        end else begin
            checks++;
            if (isqrt_x_vld[d] !== 1'b0) begin
                errors++;
                $display("FAIL %s idle_no_request: xvld=%b, want 0", nm, isqrt_x_vld[d]);
            end
            @(posedge clk); #1; cyc++;
            arg_vld[d] = 1'b0;
            @(negedge clk);
            checks++;
            if (res_vld[d] !== 1'b0 || res[d] !== eres) begin
                errors++;
                $display("FAIL %s pulse_hold: res_vld=%b res=%h, want 0 %h", nm, res_vld[d], res[d], eres);
            end
        end
    endtask

    task automatic test_reset();
        for (int d = 0; d < 3; d++) begin
            arg_vld[d] = 1'b0; args[d] = '0; isqrt_y_vld[d] = 1'b0; isqrt_y[d] = '0;
        end
        #1 rst_n = 1'b0;
        #2;
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (arg_rdy[d] !== 1'b1 || res_vld[d] !== 1'b0 || res[d] !== 32'h0 || isqrt_x_vld[d] !== 1'b0) begin
                errors++;
                $display("FAIL reset_state[%0d]: rdy=%b res_vld=%b res=%h xvld=%b, want 1 0 0 0",
                         d, arg_rdy[d], res_vld[d], res[d], isqrt_x_vld[d]);
            end
        end
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_directed();
        logic [31:0] r;
        drive_vector(0, 3, 4, {32'd16, 32'd0, 32'd0}, 0, 0, 0, 0, '0, "n3_a", r);
        checks++;
        if (obs_req[0] !== 32'd16 || obs_req[1] !== 32'd4 || obs_req[2] !== 32'd2 || r !== 32'd1) begin
            errors++;
            $display("FAIL n3_a_values: req=%0d,%0d,%0d res=%0d, want 16,4,2 res=1",
                     obs_req[0], obs_req[1], obs_req[2], r);
        end
        drive_vector(0, 3, 4, {32'd0, 32'd9, 32'd1}, 0, 0, 0, 0, '0, "n3_b", r);
        checks++;
        if (obs_req[0] !== 32'd0 || obs_req[1] !== 32'd9 || obs_req[2] !== 32'd4 || r !== 32'd2) begin
            errors++;
            $display("FAIL n3_b_values: req=%0d,%0d,%0d res=%0d, want 0,9,4 res=2",
                     obs_req[0], obs_req[1], obs_req[2], r);
        end
    endtask

    task automatic test_wrap();
        logic [31:0] r;
        drive_vector(1, 2, 4, {32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF}, 0, 0, 0, 0, '0, "n2_wrap", r);
        checks++;
        if (obs_req[1] !== 32'h0000_FFFE || r !== 32'd255) begin
            errors++;
            $display("FAIL n2_wrap_values: req1=%h res=%0d, want 0000fffe res=255", obs_req[1], r);
        end
    endtask

    task automatic test_single_operand();
        logic [31:0] r;
        drive_vector(2, 1, 1, {64'h0, 32'd100}, 0, 0, 0, 0, '0, "n1", r);
        checks++;
        if (r !== 32'd10) begin
            errors++;
            $display("FAIL n1_value: res=%0d, want 10", r);
        end
    endtask

    task automatic test_back_to_back();
        logic [95:0] v1;
        logic [95:0] v2;
        logic [31:0] r;
        v1 = rand_vec();
        v2 = rand_vec();
        drive_vector(0, 3, 3, v1, 0, 1, 0, 1, v2, "bp_first", r);
        checks++;
        if (r !== ref_formula(v1, 3)) begin
            errors++;
            $display("FAIL bp_first_value: res=%h, want %h", r, ref_formula(v1, 3));
        end
        drive_vector(0, 3, 3, v2, 1, 0, 0, 0, '0, "bp_second", r);
        checks++;
        if (r !== ref_formula(v2, 3)) begin
            errors++;
            $display("FAIL bp_second_value: res=%h, want %h", r, ref_formula(v2, 3));
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] r;
        drive_vector(0, 3, 4, rand_vec(), 0, 0, 2, 0, '0, "mid_reset", r);
        drive_vector(0, 3, 4, {32'd0, 32'd9, 32'd1}, 0, 0, 0, 0, '0, "after_reset", r);
        checks++;
        if (r !== 32'd2) begin
            errors++;
            $display("FAIL after_reset_value: res=%0d, want 2", r);
        end
    endtask

    task automatic test_random();
        logic [95:0] v;
        logic [95:0] nv;
        logic [31:0] r;
        int d;
        int n;
        int lat;
        bit chain;
        bit nchain;
        chain = 1'b0;
        d     = 0;
        v     = '0;
        for (int t = 0; t < 24; t++) begin
            if (!chain) begin
                d = $urandom_range(0, 2);
                v = rand_vec();
            end
            n      = 3 - d;
            lat    = $urandom_range(1, 5);
            nchain = ($urandom_range(0, 2) == 0) && (t != 23);
            nv     = rand_vec();
            drive_vector(d, n, lat, v, chain, $urandom_range(0, 1), 0, nchain, nv, "random", r);
            checks++;
            if (r !== ref_formula(v, n)) begin
                errors++;
                $display("FAIL random_value n=%0d lat=%0d args=%h: res=%h, want %h",
                         n, lat, v, r, ref_formula(v, n));
            end
            chain = nchain;
            v     = nv;
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_wrap();
        test_single_operand();
        test_back_to_back();
        test_reset_mid();
        test_random();
        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_formula_n_fsm
`default_nettype wire
